md5_round_sched: RTL and testbench

- Round sequencer for one MD5 compression context.
- Accepts a block-start request and drives the registered round-constant ROM (7-bit `t`, `en`, `rst` interface with 2-cycle read latency; address = t − 4).
- Emits per-round control aligned to the ROM's Kt output: message-word index, rotate amount, function select and round valid.
- Sits between the md5crypt thread scheduler and the MD5 round datapath.

---
 rtl/md5_round_sched.sv | 205 ++++++++++++++++++++
 tb/tb_md5_round_sched.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/md5_round_sched.sv
// md5_round_sched: round sequencer for one MD5 compression context.
// Issues 64 round addresses to the registered Kt ROM (2-cycle latency), then
// emits per-round controls (word index, rotate, function select) aligned to
// the ROM's Kt output.
// Optional build macro MD5_ROUND_SCHED_PERF_EN adds blk_cnt / stall_cnt.
//
// Handshake: a block is accepted on a CLK edge where start && ready; ready is
// high only in IDLE and a start while not ready is dropped, never queued.
module md5_round_sched #(
    parameter int T_OFFSET = 4,
    parameter int KT_LAT   = 2
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic        start,
    output logic        ready,
    input  logic        hold,
    input  logic        abort,
    output logic [6:0]  kt_t,
    output logic        kt_en,
    output logic        kt_rst,
    output logic        round_valid,
    output logic [5:0]  round_num,
    output logic [3:0]  wrd_idx,
    output logic [4:0]  rot,
    output logic [1:0]  fsel,
    output logic        done
`ifdef MD5_ROUND_SCHED_PERF_EN
    ,
    output logic [31:0] blk_cnt,
    output logic [31:0] stall_cnt
`endif
);

    // The control pipeline below is exactly two stages deep to match the ROM.
    if (KT_LAT != 2) begin : g_bad_kt_lat
        $error("md5_round_sched: KT_LAT must be 2");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [5:0]  cnt, cnt_nxt;
    logic        drain_cnt, drain_nxt;
    logic        aborting;
    logic [6:0]  kt_t_q;
    logic        kt_rst_q;

    logic        s1_v;
    logic [5:0]  s1_r;
    logic        s2_v;
    logic [5:0]  r_q;
    logic [3:0]  wrd_q;
    logic [4:0]  rot_q;
    logic [1:0]  fsel_q;

    // MD5 message word index g for round r (mod 16 only needs r[3:0]).
    function automatic logic [3:0] calc_wrd(input logic [5:0] r);
        logic [3:0] rl;
        rl = r[3:0];
        case (r[5:4])
            2'd0:    calc_wrd = rl;
            2'd1:    calc_wrd = rl * 4'd5 + 4'd1;
            2'd2:    calc_wrd = rl * 4'd3 + 4'd5;
            default: calc_wrd = rl * 4'd7;
        endcase
    endfunction

    // Left-rotate amount s, by round group r[5:4] and position r[1:0].
    function automatic logic [4:0] calc_rot(input logic [5:0] r);
        case ({r[5:4], r[1:0]})
            4'h0: calc_rot = 5'd7;   4'h1: calc_rot = 5'd12;
            4'h2: calc_rot = 5'd17;  4'h3: calc_rot = 5'd22;
            4'h4: calc_rot = 5'd5;   4'h5: calc_rot = 5'd9;
            4'h6: calc_rot = 5'd14;  4'h7: calc_rot = 5'd20;
            4'h8: calc_rot = 5'd4;   4'h9: calc_rot = 5'd11;
            4'hA: calc_rot = 5'd16;  4'hB: calc_rot = 5'd23;
            4'hC: calc_rot = 5'd6;   4'hD: calc_rot = 5'd10;
            4'hE: calc_rot = 5'd15;  default: calc_rot = 5'd21;
        endcase
    endfunction

    assign aborting = abort && (state != IDLE);

    // Next-state, issue counter and ROM enable; abort wins over hold.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        drain_nxt = drain_cnt;
        kt_en     = 1'b0;
        ready     = (state == IDLE);
        if (aborting) begin
            state_nxt = IDLE;
            cnt_nxt   = 6'd0;
            drain_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt = ISSUE;
                        cnt_nxt   = 6'd0;
                    end
                end
                ISSUE: begin
                    if (!hold) begin
                        kt_en = 1'b1;
                        if (cnt == 6'd63) begin
                            state_nxt = DRAIN;
                            drain_nxt = 1'b0;
                        end else begin
                            cnt_nxt = cnt + 6'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (!hold) begin
                        if (drain_cnt == 1'(KT_LAT - 1)) begin
                            state_nxt = IDLE;
                        end else begin
                            drain_nxt = drain_cnt + 1'b1;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // ROM address follows the issue counter in ISSUE and holds elsewhere.
    always_comb begin
        kt_t = kt_t_q;
        if (state == ISSUE) kt_t = {1'b0, cnt} + 7'(T_OFFSET);
    end

    // State, counters, held ROM address and the one-shot ROM clear.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 6'd0;
            drain_cnt <= 1'b0;
            kt_t_q    <= 7'd0;
            kt_rst_q  <= 1'b1;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            drain_cnt <= drain_nxt;
            kt_t_q    <= kt_t;
            kt_rst_q  <= aborting;
        end
    end

    // Two-stage valid/index pipeline matching the ROM latency; stage 2 holds
    // the registered round controls, which keep their value when idle.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            s1_v   <= 1'b0;
            s1_r   <= 6'd0;
            s2_v   <= 1'b0;
            r_q    <= 6'd0;
            wrd_q  <= 4'd0;
            rot_q  <= 5'd0;
            fsel_q <= 2'd0;
        end else if (aborting) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
        end else if (!hold) begin
            s1_v <= kt_en;
            s1_r <= cnt;
            s2_v <= s1_v;
            if (s1_v) begin
                r_q    <= s1_r;
                wrd_q  <= calc_wrd(s1_r);
                rot_q  <= calc_rot(s1_r);
                fsel_q <= s1_r[5:4];
            end
        end
    end

    assign kt_rst      = kt_rst_q;
    assign round_valid = s2_v && !hold;
    assign round_num   = r_q;
    assign wrd_idx     = wrd_q;
    assign rot         = rot_q;
    assign fsel        = fsel_q;
    assign done        = round_valid && (r_q == 6'd63);

`ifdef MD5_ROUND_SCHED_PERF_EN
    // Completed-block counter (wraps) and busy-stall counter (saturates).
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            blk_cnt   <= 32'd0;
            stall_cnt <= 32'd0;
        end else begin
            if (done) blk_cnt <= blk_cnt + 32'd1;
            if (hold && (state != IDLE) && (stall_cnt != 32'hFFFF_FFFF))
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_md5_round_sched.sv
// tb_md5_round_sched: directed bench for md5_round_sched (cycle numbering:
// inputs set in cycle C are sampled at the edge ending C; outputs are read
// 3 ns into each cycle).
module tb_md5_round_sched;

    logic        CLK;
    logic        rst_n;
    logic        start;
    logic        ready;
    logic        hold;
    logic        abort;
    logic [6:0]  kt_t;
    logic        kt_en;
    logic        kt_rst;
    logic        round_valid;
    logic [5:0]  round_num;
    logic [3:0]  wrd_idx;
    logic [4:0]  rot;
    logic [1:0]  fsel;
    logic        done;
`ifdef MD5_ROUND_SCHED_PERF_EN
    logic [31:0] blk_cnt;
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [5:0] exp_q[$];

    md5_round_sched dut (
        .CLK         (CLK),
        .rst_n       (rst_n),
        .start       (start),
        .ready       (ready),
        .hold        (hold),
        .abort       (abort),
        .kt_t        (kt_t),
        .kt_en       (kt_en),
        .kt_rst      (kt_rst),
        .round_valid (round_valid),
        .round_num   (round_num),
        .wrd_idx     (wrd_idx),
        .rot         (rot),
        .fsel        (fsel),
        .done        (done)
`ifdef MD5_ROUND_SCHED_PERF_EN
        ,
        .blk_cnt     (blk_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    // clock / watchdog
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!ready && n < 200) begin
            tick();
            #2;
            n++;
        end
        check("wait_idle", ready, 1);
    endtask

    // Hand-computed controls for selected rounds.
    task automatic check_ctrl(input int r);
        case (r)
            0:  begin check("c0_wrd", wrd_idx, 0);   check("c0_rot", rot, 7);   check("c0_fsel", fsel, 0); end
            5:  begin check("c5_wrd", wrd_idx, 5);   check("c5_rot", rot, 12);  check("c5_fsel", fsel, 0); end
            17: begin check("c17_wrd", wrd_idx, 6);  check("c17_rot", rot, 9);  check("c17_fsel", fsel, 1); end
            20: begin check("c20_wrd", wrd_idx, 5);  check("c20_rot", rot, 5);  check("c20_fsel", fsel, 1); end
            33: begin check("c33_wrd", wrd_idx, 8);  check("c33_rot", rot, 11); check("c33_fsel", fsel, 2); end
            47: begin check("c47_wrd", wrd_idx, 2);  check("c47_rot", rot, 23); check("c47_fsel", fsel, 2); end
            50: begin check("c50_wrd", wrd_idx, 14); check("c50_rot", rot, 15); check("c50_fsel", fsel, 3); end
            63: begin check("c63_wrd", wrd_idx, 9);  check("c63_rot", rot, 21); check("c63_fsel", fsel, 3); end
            default: ;
        endcase
    endtask

    initial begin
        int acc, a0, a1;
        logic [5:0] e;

        // reset
        rst_n = 1'b0; start = 1'b0; hold = 1'b0; abort = 1'b0;
        tick(); tick(); #2;
        check("rst_ready", ready, 1);
        check("rst_kt_en", kt_en, 0);
        check("rst_kt_rst", kt_rst, 1);
        check("rst_kt_t", kt_t, 0);
        check("rst_rv", round_valid, 0);
        check("rst_rnum", round_num, 0);
        check("rst_wrd", wrd_idx, 0);
        check("rst_rot", rot, 0);
        check("rst_fsel", fsel, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        tick(); #2;
        check("post_rst_kt_rst", kt_rst, 0);

        // full block, no hold
        start = 1'b1;
        for (int k = 1; k <= 67; k++) begin
            tick();
            start = 1'b0;
            #2;
            check("a_kt_en", kt_en, (k <= 64));
            check("a_kt_t", kt_t, (k <= 64) ? k + 3 : 67);
            check("a_rv", round_valid, (k >= 3 && k <= 66));
            if (round_valid) begin
                check("a_rnum", round_num, k - 3);
                check_ctrl(k - 3);
            end
            check("a_done", done, (k == 66));
            check("a_ready", ready, (k == 67));
            check("a_kt_rst", kt_rst, 0);
        end

        // hold for 5 cycles at issue i=20
        for (int r = 0; r < 64; r++) exp_q.push_back(6'(r));
        start = 1'b1;
        for (int k = 1; k <= 72; k++) begin
            tick();
            start = 1'b0;
            hold  = (k >= 21 && k <= 25);
            #2;
            check("b_kt_en", kt_en, (k <= 20) || (k >= 26 && k <= 69));
            if (kt_en) check("b_kt_t", kt_t, (k <= 20) ? k + 3 : k - 2);
            check("b_rv", round_valid, (k >= 3 && k <= 20) || (k >= 26 && k <= 71));
            if (round_valid) begin
                if (exp_q.size() == 0) begin
                    check("b_q_empty", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("b_rnum", round_num, e);
                end
            end
            check("b_done", done, (k == 71));
            check("b_ready", ready, (k == 72));
        end
        hold = 1'b0;
        check("b_q_left", exp_q.size(), 0);

        // abort at C+30, restart at C+31
        start = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            start = 1'b0;
            abort = (k == 30);
            #2;
        end
        check("c_kt_t_30", kt_t, 33);
        tick();
        abort = 1'b0;
        start = 1'b1;
        #2;
        check("c_kt_rst_31", kt_rst, 1);
        check("c_rv_31", round_valid, 0);
        check("c_ready_31", ready, 1);
        check("c_kt_en_31", kt_en, 0);
        check("c_kt_t_31", kt_t, 33);
        check("c_done_31", done, 0);
        tick();
        start = 1'b0;
        #2;
        check("c_kt_rst_32", kt_rst, 0);
        check("c_kt_en_32", kt_en, 1);
        check("c_kt_t_32", kt_t, 4);
        check("c_rv_32", round_valid, 0);
        check("c_ready_32", ready, 0);
        tick(); #2;
        check("c_rv_33", round_valid, 0);
        tick(); #2;
        check("c_rv_34", round_valid, 1);
        check("c_rnum_34", round_num, 0);
        check_ctrl(0);
        wait_idle();

        // start held high continuously
        acc = 0; a0 = -1; a1 = -1;
        start = 1'b1;
        for (int k = 0; k <= 100; k++) begin
            if (k > 0) begin
                tick();
                #2;
            end
            if (ready && start) begin
                if (acc == 0) a0 = k;
                else if (acc == 1) a1 = k;
                acc++;
            end
        end
        start = 1'b0;
        check("d_accepts", acc, 2);
        check("d_first", a0, 0);
        check("d_second", a1, 67);
        wait_idle();

        // hold in IDLE does not block start
        hold  = 1'b1;
        start = 1'b1;
        tick();
        hold  = 1'b0;
        start = 1'b0;
        #2;
        check("e_ready", ready, 0);
        check("e_kt_en", kt_en, 1);
        check("e_kt_t", kt_t, 4);
        wait_idle();

`ifdef MD5_ROUND_SCHED_PERF_EN
        // performance counters
        rst_n = 1'b0;
        tick(); #2;
        check("p_blk_rst", blk_cnt, 0);
        check("p_stall_rst", stall_cnt, 0);
        rst_n = 1'b1;
        tick();
        hold = 1'b1;
        tick(); tick();
        hold = 1'b0;
        for (int b = 0; b < 3; b++) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            repeat (5) tick();
            if (b == 0) begin
                hold = 1'b1;
                repeat (7) tick();
                hold = 1'b0;
            end
            #2;
            wait_idle();
        end
        check("p_blk", blk_cnt, 3);
        check("p_stall", stall_cnt, 7);
        rst_n = 1'b0;
        tick(); #2;
        check("p_blk_clr", blk_cnt, 0);
        check("p_stall_clr", stall_cnt, 0);
        rst_n = 1'b1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
